// File: rtl/gnn_node_sched_if.sv
// Bundle of the scheduler's feature-store, datapath and result signals.
// master = scheduler side, slave = environment (feature store, datapath, consumer).
interface gnn_node_sched_if #(
    parameter int NUM_NODES = 4,
    parameter int NODE_W    = 3
);
    logic                           start;
    logic [NUM_NODES*NUM_NODES-1:0] adj;
    logic [NODE_W-1:0]              feat_addr;
    logic [27:0]                    feat_data;
    logic                           dp_in_ready;
    logic [27:0]                    dp_x;
    logic [59:0]                    dp_y_relu;
    logic [67:0]                    dp_y_aggr;
    logic                           dp_out0_ready;
    logic [20:0]                    dp_out0;
    logic [20:0]                    dp_out1;
    logic                           res_valid;
    logic [NODE_W-1:0]              res_node;
    logic [20:0]                    res_out0;
    logic [20:0]                    res_out1;
    logic                           busy;
    logic                           done;
    logic                           err;
    logic [2:0]                     dbg_state;

    // Handshake: dp_in_ready is a one-cycle issue strobe; dp_out0_ready must be
    // high in the L2_WAIT cycle or the run aborts with err; res_valid is a
    // one-cycle pulse with no back-pressure.
    modport master (
        input  start, adj, feat_data, dp_y_relu, dp_out0_ready, dp_out0, dp_out1,
        output feat_addr, dp_in_ready, dp_x, dp_y_aggr, res_valid, res_node,
               res_out0, res_out1, busy, done, err, dbg_state
    );

    modport slave (
        output start, adj, feat_data, dp_y_relu, dp_out0_ready, dp_out0, dp_out1,
        input  feat_addr, dp_in_ready, dp_x, dp_y_aggr, res_valid, res_node,
               res_out0, res_out1, busy, done, err, dbg_state
    );
endinterface

// File: rtl/gnn_node_sched.sv
// Two-layer GNN inference sequencer: layer-1 pass over all nodes into a buffer,
// then per-node neighbour aggregation and a layer-2 pass on the shared datapath.
module gnn_node_sched #(
    parameter int NUM_NODES = 4,
    parameter int NODE_W    = 3
) (
    input logic             clk,
    input logic             rst,
    gnn_node_sched_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, L1_ISSUE, L1_CAPTURE, AGG, L2_ISSUE, L2_PRESENT, L2_WAIT, DONE
    } state_t;

    localparam logic [NODE_W-1:0] LAST = NODE_W'(NUM_NODES - 1);

    state_t            state;
    logic [NODE_W-1:0] n, i, j;
    logic [59:0]       node_buf [NUM_NODES];
    logic [16:0]       acc [4];
    logic              adj_bit;
    logic [59:0]       sel_relu;

    // Constant-index muxes keep the adjacency/buffer selects free of index-width issues.
    always_comb begin
        adj_bit  = 1'b0;
        sel_relu = '0;
        for (int k = 0; k < NUM_NODES; k++) begin
            if (NODE_W'(k) == j) sel_relu = node_buf[k];
        end
        for (int r = 0; r < NUM_NODES; r++) begin
            for (int c = 0; c < NUM_NODES; c++) begin
                if (NODE_W'(r) == i && NODE_W'(c) == j) adj_bit = bus.adj[r*NUM_NODES + c];
            end
        end
    end

    assign bus.feat_addr = n;
    assign bus.dp_x      = (state == L1_ISSUE) ? bus.feat_data : '0;
    assign bus.dp_y_aggr = {acc[3], acc[2], acc[1], acc[0]};
    assign bus.dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            n               <= '0;
            i               <= '0;
            j               <= '0;
            bus.dp_in_ready <= 1'b0;
            bus.res_valid   <= 1'b0;
            bus.res_node    <= '0;
            bus.res_out0    <= '0;
            bus.res_out1    <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
            for (int k = 0; k < NUM_NODES; k++) node_buf[k] <= '0;
            for (int c = 0; c < 4; c++) acc[c] <= '0;
        end else begin
            bus.res_valid   <= 1'b0;
            bus.done        <= 1'b0;
            bus.dp_in_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state           <= L1_ISSUE;
                        n               <= '0;
                        bus.err         <= 1'b0;
                        bus.busy        <= 1'b1;
                        bus.dp_in_ready <= 1'b1;
                    end
                end
                L1_ISSUE: state <= L1_CAPTURE;
                L1_CAPTURE: begin
                    for (int k = 0; k < NUM_NODES; k++) begin
                        if (NODE_W'(k) == n) node_buf[k] <= bus.dp_y_relu;
                    end
                    if (n == LAST) begin
                        state <= AGG;
                        i     <= '0;
                        j     <= '0;
                    end else begin
                        n               <= n + 1'b1;
                        state           <= L1_ISSUE;
                        bus.dp_in_ready <= 1'b1;
                    end
                end
                AGG: begin
                    // j==0 restarts the sum so no separate clear cycle is needed per node.
                    for (int c = 0; c < 4; c++) begin
                        acc[c] <= ((j == '0) ? 17'd0 : acc[c]) +
                                  (adj_bit ? {2'b00, sel_relu[c*15 +: 15]} : 17'd0);
                    end
                    if (j == LAST) begin
                        state           <= L2_ISSUE;
                        bus.dp_in_ready <= 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                L2_ISSUE:   state <= L2_PRESENT;
                L2_PRESENT: state <= L2_WAIT;
                L2_WAIT: begin
                    if (bus.dp_out0_ready) begin
                        bus.res_out0  <= bus.dp_out0;
                        bus.res_out1  <= bus.dp_out1;
                        bus.res_node  <= i;
                        bus.res_valid <= 1'b1;
                        if (i == LAST) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            i     <= i + 1'b1;
                            j     <= '0;
                            state <= AGG;
                        end
                    end else begin
                        bus.err  <= 1'b1;
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gnn_node_sched.sv
// Directed bench for gnn_node_sched with a behavioural unit-weight datapath model.
module tb_gnn_node_sched;
    localparam int N = 4;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gnn_node_sched_if #(.NUM_NODES(N), .NODE_W(W)) bus();
    gnn_node_sched #(.NUM_NODES(N), .NODE_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Feature store and datapath model (all weights 1, layer-1 ReLU, one cycle per stage).
    logic [27:0] feat_mem [8];
    logic        force_nready = 1'b0;
    logic        d1 = 1'b0;
    logic        ordy = 1'b0;
    logic [59:0] relu_q = '0;
    logic [20:0] out_q = '0;

    assign bus.feat_data     = feat_mem[bus.feat_addr];
    assign bus.dp_y_relu     = relu_q;
    assign bus.dp_out0_ready = ordy;
    assign bus.dp_out0       = out_q;
    assign bus.dp_out1       = out_q;

    function automatic logic [14:0] l1_relu(input logic [27:0] x);
        int s = 0;
        for (int k = 0; k < 4; k++) s += int'($signed(x[k*7 +: 7]));
        return (s < 0) ? 15'd0 : 15'(s);
    endfunction

    function automatic logic [20:0] l2_out(input logic [67:0] a);
        int s = 0;
        for (int k = 0; k < 4; k++) s += int'(a[k*17 +: 17]);
        return 21'(s);
    endfunction

    always @(posedge clk) begin
        if (bus.dp_in_ready) relu_q <= {4{l1_relu(bus.dp_x)}};
        d1 <= bus.dp_in_ready;
        if (d1) out_q <= l2_out(bus.dp_y_aggr);
        ordy <= d1 && !force_nready;
    end

    // Run recording
    int          rv_cyc[$];
    logic [2:0]  rv_node[$];
    logic [20:0] rv_o0[$];
    logic [20:0] rv_o1[$];
    int          done_cyc[$];
    logic        busy_hist [64];
    logic        err_hist [64];
    logic        snap_busy, snap_rv, snap_done, snap_err, snap_rdy;
    logic [20:0] snap_o0, snap_o1;
    logic [67:0] snap_aggr;

    task automatic set_feats(input logic [27:0] node2);
        for (int k = 0; k < 8; k++) feat_mem[k] = {7'd1, 7'd1, 7'd1, 7'd1};
        feat_mem[2] = node2;
    endtask

    // Start pulse sampled at the end of cycle 0; cycles 1..ncyc sampled mid-cycle.
    task automatic run_capture(input int ncyc, input int restart_at, input int rst_at);
        rv_cyc.delete(); rv_node.delete(); rv_o0.delete(); rv_o1.delete(); done_cyc.delete();
        for (int c = 0; c < 64; c++) begin busy_hist[c] = 1'b0; err_hist[c] = 1'b0; end
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            busy_hist[c] = bus.busy;
            err_hist[c]  = bus.err;
            if (bus.res_valid) begin
                rv_cyc.push_back(c); rv_node.push_back(bus.res_node);
                rv_o0.push_back(bus.res_out0); rv_o1.push_back(bus.res_out1);
            end
            if (bus.done) done_cyc.push_back(c);
            if (c == rst_at + 1) begin
                snap_busy = bus.busy; snap_rv = bus.res_valid; snap_done = bus.done;
                snap_err = bus.err; snap_rdy = bus.dp_in_ready; snap_o0 = bus.res_out0;
                snap_o1 = bus.res_out1; snap_aggr = bus.dp_y_aggr;
            end
            if (c == restart_at) bus.start = 1'b1;
            if (c == restart_at + 1) bus.start = 1'b0;
            if (c == rst_at) rst = 1'b1;
            if (c == rst_at + 2) rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.adj = '0; set_feats({7'd1, 7'd1, 7'd1, 7'd1});
        repeat (2) @(negedge clk);
        checks += 8;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        if (bus.res_out0 !== 21'd0) begin errors++; $display("FAIL reset_res_out0: got %0d want 0", bus.res_out0); end
        if (bus.dp_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.dp_in_ready); end
        if (bus.dp_y_aggr !== 68'd0) begin errors++; $display("FAIL reset_aggr: got %h want 0", bus.dp_y_aggr); end
        if (bus.dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int exp_c[4] = '{16, 23, 30, 37};
        set_feats({7'd1, 7'd1, 7'd1, 7'd1});
        bus.adj = 16'h8421;
        run_capture(45, -1, -1);
        checks++;
        if (rv_cyc.size() != 4) begin errors++; $display("FAIL ident_rv_count: got %0d want 4", rv_cyc.size()); end
        for (int k = 0; k < 4 && k < rv_cyc.size(); k++) begin
            checks += 4;
            if (rv_cyc[k] != exp_c[k]) begin errors++; $display("FAIL ident_rv_cycle[%0d]: got %0d want %0d", k, rv_cyc[k], exp_c[k]); end
            if (rv_node[k] !== 3'(k)) begin errors++; $display("FAIL ident_node[%0d]: got %0d want %0d", k, rv_node[k], k); end
            if (rv_o0[k] !== 21'd16) begin errors++; $display("FAIL ident_out0[%0d]: got %0d want 16", k, rv_o0[k]); end
            if (rv_o1[k] !== 21'd16) begin errors++; $display("FAIL ident_out1[%0d]: got %0d want 16", k, rv_o1[k]); end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 37) begin
            errors++; $display("FAIL ident_done: got count %0d first %0d want one at 37", done_cyc.size(),
                               (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        for (int c = 1; c <= 38; c++) begin
            checks++;
            if (busy_hist[c] !== (c <= 37)) begin errors++; $display("FAIL ident_busy[%0d]: got %b want %b", c, busy_hist[c], c <= 37); end
        end
        checks++;
        if (err_hist[37] !== 1'b0) begin errors++; $display("FAIL ident_err: got %b want 0", err_hist[37]); end
    endtask

    task automatic test_all_ones();
        set_feats({7'd1, 7'd1, 7'd1, 7'd1});
        bus.adj = 16'hFFFF;
        run_capture(45, -1, -1);
        checks++;
        if (rv_cyc.size() != 4) begin errors++; $display("FAIL ones_rv_count: got %0d want 4", rv_cyc.size()); end
        for (int k = 0; k < rv_cyc.size(); k++) begin
            checks += 2;
            if (rv_o0[k] !== 21'd64) begin errors++; $display("FAIL ones_out0[%0d]: got %0d want 64", k, rv_o0[k]); end
            if (rv_o1[k] !== 21'd64) begin errors++; $display("FAIL ones_out1[%0d]: got %0d want 64", k, rv_o1[k]); end
        end
    endtask

    task automatic test_relu_neg();
        logic [20:0] exp_id[4] = '{21'd16, 21'd16, 21'd0, 21'd16};
        set_feats({4{7'h7F}});
        bus.adj = 16'hFFFF;
        run_capture(45, -1, -1);
        checks++;
        if (rv_cyc.size() != 4) begin errors++; $display("FAIL neg_ones_count: got %0d want 4", rv_cyc.size()); end
        for (int k = 0; k < rv_cyc.size(); k++) begin
            checks++;
            if (rv_o0[k] !== 21'd48) begin errors++; $display("FAIL neg_ones_out0[%0d]: got %0d want 48", k, rv_o0[k]); end
        end
        bus.adj = 16'h8421;
        run_capture(45, -1, -1);
        checks++;
        if (rv_cyc.size() != 4) begin errors++; $display("FAIL neg_ident_count: got %0d want 4", rv_cyc.size()); end
        for (int k = 0; k < rv_cyc.size(); k++) begin
            checks++;
            if (rv_o1[k] !== exp_id[k]) begin errors++; $display("FAIL neg_ident_out1[%0d]: got %0d want %0d", k, rv_o1[k], exp_id[k]); end
        end
    endtask

    task automatic test_restart_ignored();
        set_feats({7'd1, 7'd1, 7'd1, 7'd1});
        bus.adj = 16'h8421;
        run_capture(50, 10, -1);
        checks += 3;
        if (rv_cyc.size() != 4) begin errors++; $display("FAIL restart_rv_count: got %0d want 4", rv_cyc.size()); end
        if (done_cyc.size() != 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", done_cyc.size()); end
        if (rv_cyc.size() > 3 && rv_cyc[3] != 37) begin errors++; $display("FAIL restart_last_cycle: got %0d want 37", rv_cyc[3]); end
    endtask

    task automatic test_reset_abort();
        set_feats({7'd1, 7'd1, 7'd1, 7'd1});
        bus.adj = 16'h8421;
        run_capture(45, -1, 20);
        checks += 8;
        if (rv_cyc.size() != 1) begin errors++; $display("FAIL abort_rv_count: got %0d want 1", rv_cyc.size()); end
        if (done_cyc.size() != 0) begin errors++; $display("FAIL abort_done_count: got %0d want 0", done_cyc.size()); end
        if (snap_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", snap_busy); end
        if (snap_rv !== 1'b0 || snap_done !== 1'b0 || snap_err !== 1'b0) begin
            errors++; $display("FAIL abort_pulses: got rv=%b done=%b err=%b want 0", snap_rv, snap_done, snap_err);
        end
        if (snap_rdy !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b want 0", snap_rdy); end
        if (snap_o0 !== 21'd0) begin errors++; $display("FAIL abort_out0: got %0d want 0", snap_o0); end
        if (snap_o1 !== 21'd0) begin errors++; $display("FAIL abort_out1: got %0d want 0", snap_o1); end
        if (snap_aggr !== 68'd0) begin errors++; $display("FAIL abort_aggr: got %h want 0", snap_aggr); end
        run_capture(45, -1, -1);
        checks += 3;
        if (rv_cyc.size() != 4) begin errors++; $display("FAIL rerun_rv_count: got %0d want 4", rv_cyc.size()); end
        if (rv_cyc.size() > 0 && (rv_cyc[0] != 16 || rv_o0[0] !== 21'd16)) begin
            errors++; $display("FAIL rerun_first: got cycle %0d out %0d want cycle 16 out 16", rv_cyc[0], rv_o0[0]);
        end
        if (done_cyc.size() != 1 || done_cyc[0] != 37) begin errors++; $display("FAIL rerun_done: got count %0d want one at 37", done_cyc.size()); end
    endtask

    task automatic test_err();
        set_feats({7'd1, 7'd1, 7'd1, 7'd1});
        bus.adj = 16'h8421;
        force_nready = 1'b1;
        run_capture(25, -1, -1);
        force_nready = 1'b0;
        checks += 6;
        if (rv_cyc.size() != 0) begin errors++; $display("FAIL err_rv_count: got %0d want 0", rv_cyc.size()); end
        if (done_cyc.size() != 1 || done_cyc[0] != 16) begin errors++; $display("FAIL err_done: got count %0d want one at 16", done_cyc.size()); end
        if (err_hist[15] !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", err_hist[15]); end
        if (err_hist[16] !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_hist[16]); end
        if (err_hist[25] !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_hist[25]); end
        if (busy_hist[17] !== 1'b0) begin errors++; $display("FAIL err_busy_drop: got %b want 0", busy_hist[17]); end
        run_capture(45, -1, -1);
        checks += 2;
        if (err_hist[1] !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err_hist[1]); end
        if (rv_cyc.size() != 4) begin errors++; $display("FAIL err_rerun_count: got %0d want 4", rv_cyc.size()); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_ones();
        test_relu_neg();
        test_restart_ignored();
        test_reset_abort();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
